// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------------------------
// writeback_unit
//   Write side of the register file. Merges memory-load results and ALU results onto the single
//   bank write port. Memory results always win; ALU results wait in a small FIFO when the port is
//   taken and fall straight through when the FIFO is empty and memory is idle. Writes to r0 are
//   consumed but never raise We.
//
//   Optional build macro: WB_BYPASS_EN adds a combinational forwarding lookup
//   (byp_addr / byp_hit / byp_data) over the live FIFO entries and the registered write.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   alu_valid/alu_ready         ALU result handshake; alu_addr/alu_data carry the result
//   mem_valid                   load result present (always accepted); mem_addr/mem_data
//   addr_rd, rd, We             registered bank write port
//   busy                        FIFO non-empty or a write is on the port
//   byp_addr, byp_hit, byp_data forwarding lookup (WB_BYPASS_EN only)
// ---------------------------------------------------------------------------------------------
module writeback_unit #(
    parameter int unsigned REG_ADDRESS_SIZE = 5,
    parameter int unsigned REG_SIZE         = 32,
    parameter int unsigned ALU_FIFO_DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [REG_ADDRESS_SIZE-1:0] alu_addr,
    input  logic [REG_SIZE-1:0]         alu_data,
    input  logic                        mem_valid,
    input  logic [REG_ADDRESS_SIZE-1:0] mem_addr,
    input  logic [REG_SIZE-1:0]         mem_data,
    output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
    output logic [REG_SIZE-1:0]         rd,
    output logic                        We,
`ifdef WB_BYPASS_EN
    input  logic [REG_ADDRESS_SIZE-1:0] byp_addr,
    output logic                        byp_hit,
    output logic [REG_SIZE-1:0]         byp_data,
`endif
    output logic                        busy
);

    localparam int unsigned PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(ALU_FIFO_DEPTH + 1);

    logic [REG_ADDRESS_SIZE-1:0] fifo_addr [ALU_FIFO_DEPTH];
    logic [REG_SIZE-1:0]         fifo_data [ALU_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic                        fifo_empty;
    logic                        accept;
    logic                        push;
    logic                        pop;
    logic                        fall_through;
    logic [REG_ADDRESS_SIZE-1:0] addr_d;
    logic [REG_SIZE-1:0]         rd_d;
    logic                        we_d;

    always_comb begin
        fifo_empty   = (count_q == '0);
        // Ready depends only on the registered count: a pop never frees a slot the same cycle.
        alu_ready    = (count_q < CNT_W'(ALU_FIFO_DEPTH));
        accept       = alu_valid & alu_ready;
        pop          = !mem_valid && !fifo_empty;
        fall_through = !mem_valid && fifo_empty && accept;
        push         = accept && !fall_through;

        addr_d = addr_rd;
        rd_d   = rd;
        we_d   = 1'b0;
        if (mem_valid) begin
            addr_d = mem_addr;
            rd_d   = mem_data;
            we_d   = (mem_addr != '0);
        end else if (pop) begin
            addr_d = fifo_addr[rd_ptr_q];
            rd_d   = fifo_data[rd_ptr_q];
            we_d   = (fifo_addr[rd_ptr_q] != '0);
        end else if (fall_through) begin
            addr_d = alu_addr;
            rd_d   = alu_data;
            we_d   = (alu_addr != '0);
        end

        busy = !fifo_empty || We;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_rd  <= '0;
            rd       <= '0;
            We       <= 1'b0;
        end else begin
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            addr_rd <= addr_d;
            rd      <= rd_d;
            We      <= we_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= alu_addr;
            fifo_data[wr_ptr_q] <= alu_data;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] byp_idx;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (We && (addr_rd == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = rd;
        end
        for (int unsigned i = 0; i < ALU_FIFO_DEPTH; i++) begin
            byp_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr[byp_idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = fifo_data[byp_idx];
            end
        end
        if (byp_addr == '0) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end
`else
    // No forwarding lookup in this build.
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_writeback_unit
//   Self-checking bench for writeback_unit. Every expected bank write is pushed to a scoreboard
//   queue when the stimulus is driven; a negedge monitor pops and compares on each We pulse.
//   Directed checks cover reset, latency, priority, back-pressure, r0 and mid-run reset.
// ---------------------------------------------------------------------------------------------
module tb_writeback_unit;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] rd;
    logic          We;
    logic          busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_addr = '0;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;
    wr_t exp_q[$];

    writeback_unit #(
        .REG_ADDRESS_SIZE(AW),
        .REG_SIZE        (DW),
        .ALU_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .addr_rd  (addr_rd),
        .rd       (rd),
        .We       (We),
`ifdef WB_BYPASS_EN
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && reset && We) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_write", 32'(We), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("sb_addr", 32'(addr_rd), 32'(e.addr));
                check_eq("sb_data", rd, e.data);
            end
        end
    end

    // FIFO can neither overflow nor be popped while empty.
    always @(negedge clk) begin
        if (reset) begin
            assert (int'(dut.count_q) <= int'(DEPTH))
            else $error("FAIL fifo_overflow count=%0d", dut.count_q);
            assert (!(dut.pop && dut.count_q == '0))
            else $error("FAIL fifo_underflow");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic rdy;
        logic [AW-1:0] a_addr[3];
        logic [DW-1:0] a_data[3];

        // 1. Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            mem_valid = 1'($urandom_range(0, 1));
            alu_addr  = AW'($urandom);
            mem_addr  = AW'($urandom);
            alu_data  = $urandom;
            mem_data  = $urandom;
            tick();
            check_eq("rst_we", 32'(We), 32'd0);
            check_eq("rst_addr", 32'(addr_rd), 32'd0);
            check_eq("rst_rd", rd, 32'd0);
        end
        idle();
        reset = 1'b1;
        #1;
        check_eq("rst_ready", 32'(alu_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        tick();

        // 2. ALU only: one-cycle latency, then We drops.
        alu_valid = 1'b1;
        alu_addr  = 5'd3;
        alu_data  = 32'h11;
        expect_wr(5'd3, 32'h11);
        tick();
        idle();
        check_eq("alu_we", 32'(We), 32'd1);
        check_eq("alu_addr", 32'(addr_rd), 32'd3);
        check_eq("alu_rd", rd, 32'h11);
        tick();
        check_eq("alu_we_drop", 32'(We), 32'd0);

        // Back-to-back fall-through writes, one per cycle.
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1;
            alu_addr  = AW'(i + 1);
            alu_data  = $urandom;
            expect_wr(alu_addr, alu_data);
            tick();
            check_eq("b2b_we", 32'(We), 32'd1);
        end
        idle();
        tick();

        // 3. Memory and ALU in the same cycle: memory first.
        mem_valid = 1'b1;
        mem_addr  = 5'd5;
        mem_data  = 32'hAA;
        alu_valid = 1'b1;
        alu_addr  = 5'd6;
        alu_data  = 32'hBB;
        expect_wr(5'd5, 32'hAA);
        expect_wr(5'd6, 32'hBB);
        tick();
        idle();
        check_eq("pri_first", 32'(addr_rd), 32'd5);
        check_eq("pri_busy", 32'(busy), 32'd1);
        tick();
        check_eq("pri_second", 32'(addr_rd), 32'd6);
        check_eq("pri_second_rd", rd, 32'hBB);
        check_eq("pri_second_we", 32'(We), 32'd1);
        tick();
        check_eq("pri_idle_we", 32'(We), 32'd0);
        check_eq("pri_idle_busy", 32'(busy), 32'd0);

        // 4. Sustained memory traffic with three ALU results offered.
        for (int i = 0; i < 4; i++) expect_wr(AW'(8 + i), 32'h100 + i);
        for (int i = 0; i < 3; i++) begin
            a_addr[i] = AW'(12 + i);
            a_data[i] = 32'h200 + i;
            expect_wr(a_addr[i], a_data[i]);
        end
        k = 0;
        for (int c = 0; c < 8; c++) begin
            mem_valid = (c < 4);
            mem_addr  = AW'(8 + c);
            mem_data  = 32'h100 + c;
            alu_valid = (k < 3);
            alu_addr  = a_addr[k < 3 ? k : 2];
            alu_data  = a_data[k < 3 ? k : 2];
            rdy = alu_ready;
            if (c == 2) begin
                check_eq("bp_pushes", k, 32'd2);
                check_eq("bp_ready_low", 32'(rdy), 32'd0);
            end
            if (c == 4) check_eq("bp_no_ready_through_pop", 32'(rdy), 32'd0);
            tick();
            if (rdy && alu_valid) k++;
        end
        idle();
        check_eq("bp_all_accepted", k, 32'd3);
        check_eq("bp_drained", 32'(busy), 32'd0);

        // 5. r0 destination: queued behind memory, then direct fall-through.
        mem_valid = 1'b1;
        mem_addr  = 5'd9;
        mem_data  = 32'h55;
        alu_valid = 1'b1;
        alu_addr  = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        expect_wr(5'd9, 32'h55);
        tick();
        idle();
        check_eq("r0_mem_we", 32'(We), 32'd1);
        check_eq("r0_queued", 32'(busy), 32'd1);
        tick();
        check_eq("r0_pop_we", 32'(We), 32'd0);
        check_eq("r0_popped", 32'(busy), 32'd0);
        alu_valid = 1'b1;
        tick();
        idle();
        check_eq("r0_ft_we", 32'(We), 32'd0);
        tick();

        // Reset asserted mid-operation drops queued entries and We at once.
        mem_valid = 1'b1;
        mem_addr  = 5'd1;
        mem_data  = 32'h1;
        alu_valid = 1'b1;
        alu_addr  = 5'd2;
        alu_data  = 32'h2;
        expect_wr(5'd1, 32'h1);
        tick();
        mem_addr = 5'd3;
        mem_data = 32'h3;
        alu_addr = 5'd4;
        alu_data = 32'h4;
        tick();
        idle();
        check_eq("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_eq("mid_we", 32'(We), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_eq("mid_after_we", 32'(We), 32'd0);
        check_eq("mid_after_ready", 32'(alu_ready), 32'd1);

`ifdef WB_BYPASS_EN
        // 6. Forwarding lookup picks the youngest match.
        mem_valid = 1'b1;
        mem_addr  = 5'd20;
        mem_data  = 32'h20;
        alu_valid = 1'b1;
        alu_addr  = 5'd7;
        alu_data  = 32'h1;
        expect_wr(5'd20, 32'h20);
        expect_wr(5'd21, 32'h21);
        expect_wr(5'd22, 32'h22);
        expect_wr(5'd7, 32'h1);
        expect_wr(5'd7, 32'h2);
        tick();
        mem_addr = 5'd21;
        mem_data = 32'h21;
        alu_data = 32'h2;
        check_eq("byp_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        mem_addr  = 5'd22;
        mem_data  = 32'h22;
        byp_addr  = 5'd7;
        #1;
        check_eq("byp_hit7", 32'(byp_hit), 32'd1);
        check_eq("byp_data7", byp_data, 32'h2);
        byp_addr = 5'd21;
        #1;
        check_eq("byp_hit_out", 32'(byp_hit), 32'd1);
        check_eq("byp_data_out", byp_data, 32'h21);
        byp_addr = 5'd0;
        #1;
        check_eq("byp_hit_r0", 32'(byp_hit), 32'd0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
`endif

        tick();
        tick();
        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
